// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control decode, WIDTH-bit ALU, and an iterative mul/div unit
// that holds the architectural HI/LO registers.
module alu_ctrl_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             stall,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_NOR  = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_SRA  = 4'b1010;
  localparam logic [3:0] C_SLTU = 4'b1011;
  localparam logic [3:0] C_MFHI = 4'b1100;
  localparam logic [3:0] C_MFLO = 4'b1101;
  localparam logic [3:0] C_MD   = 4'b1110;

  localparam logic [WIDTH-1:0]   ONE       = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2      = (2*WIDTH)'(1);
  localparam logic [SHW-1:0]     LAST_STEP = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state, state_d;
  logic               busy_d, md_done_d;
  logic               is_md_start, is_mthi, is_mtlo, start;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic               op_div, neg_q, neg_r, div0;
  logic               signed_op, sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   hi_fin, lo_fin;

  // ALUOp / funct decode
  always_comb begin
    alu_ctrl = C_ADD;
    case (alu_op)
      2'b00: alu_ctrl = C_ADD;
      2'b01: alu_ctrl = C_SUB;
      2'b11: alu_ctrl = C_OR;
      default: begin
        case (funct)
          6'b100000, 6'b100001: alu_ctrl = C_ADD;
          6'b100010, 6'b100011: alu_ctrl = C_SUB;
          6'b100100:            alu_ctrl = C_AND;
          6'b100101:            alu_ctrl = C_OR;
          6'b100110:            alu_ctrl = C_XOR;
          6'b100111:            alu_ctrl = C_NOR;
          6'b101010:            alu_ctrl = C_SLT;
          6'b101011:            alu_ctrl = C_SLTU;
          6'b000000:            alu_ctrl = C_SLL;
          6'b000010:            alu_ctrl = C_SRL;
          6'b000011:            alu_ctrl = C_SRA;
          6'b010000:            alu_ctrl = C_MFHI;
          6'b010010:            alu_ctrl = C_MFLO;
          6'b010001, 6'b010011, 6'b011000,
          6'b011001, 6'b011010, 6'b011011: alu_ctrl = C_MD;
          default:              alu_ctrl = C_ADD;
        endcase
      end
    endcase
  end

  // HI/LO consumers must wait while the unit is busy
  assign stall = valid_in & busy &
                 ((alu_ctrl == C_MD) | (alu_ctrl == C_MFHI) | (alu_ctrl == C_MFLO));

  // Combinational ALU; a stalled instruction produces 0
  always_comb begin
    result = '0;
    if (!stall) begin
      case (alu_ctrl)
        C_AND:   result = a & b;
        C_OR:    result = a | b;
        C_ADD:   result = a + b;
        C_XOR:   result = a ^ b;
        C_NOR:   result = ~(a | b);
        C_SUB:   result = a - b;
        C_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        C_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
        C_SLL:   result = b << shamt;
        C_SRL:   result = b >> shamt;
        C_SRA:   result = WIDTH'($signed(b) >>> shamt);
        C_MFHI:  result = hi;
        C_MFLO:  result = lo;
        default: result = '0;
      endcase
    end
  end

  assign zero = (result == '0);

  assign is_md_start = (alu_op == 2'b10) && (funct[5:2] == 4'b0110);
  assign is_mthi     = (alu_op == 2'b10) && (funct == 6'b010001);
  assign is_mtlo     = (alu_op == 2'b10) && (funct == 6'b010011);
  assign start       = valid_in & is_md_start & ~stall & (state == S_IDLE);

  // Operand magnitudes for signed ops (funct[0]==0 means signed)
  always_comb begin
    signed_op = ~funct[0];
    sgn_a     = signed_op & a[WIDTH-1];
    sgn_b     = signed_op & b[WIDTH-1];
    mag_a     = sgn_a ? (~a + ONE) : a;
    mag_b     = sgn_b ? (~b + ONE) : b;
  end

  // One shift-add / restoring-subtract step, plus sign fix-up of the final result
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift - {1'b0, mcand};
    prod_fin  = neg_q ? (~{acc_hi, acc_lo} + ONE2) : {acc_hi, acc_lo};
    if (op_div) begin
      lo_fin = div0 ? '1 : (neg_q ? (~acc_lo + ONE) : acc_lo);
      hi_fin = neg_r ? (~acc_hi + ONE) : acc_hi;
    end else begin
      hi_fin = prod_fin[2*WIDTH-1:WIDTH];
      lo_fin = prod_fin[WIDTH-1:0];
    end
  end

  // FSM state register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      md_done <= 1'b0;
    end else begin
      state   <= state_d;
      busy    <= busy_d;
      md_done <= md_done_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt == LAST_STEP) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs (captured by the state register)
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    md_done_d = (state == S_DONE);
  end

  // Operand latches, iteration datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (start) begin
        cnt    <= '0;
        op_div <= funct[1];
        neg_q  <= sgn_a ^ sgn_b;
        neg_r  <= sgn_a;
        div0   <= (b == '0);
        acc_hi <= '0;
        mcand  <= funct[1] ? mag_b : mag_a;
        acc_lo <= funct[1] ? mag_a : mag_b;
      end else if (state == S_RUN) begin
        cnt <= cnt + SHW'(1);
        if (op_div) begin
          acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end
      if (state == S_DONE) begin
        hi <= hi_fin;
        lo <= lo_fin;
      end else if (valid_in && !busy) begin
        if (is_mthi) hi <= a;
        if (is_mtlo) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Randomized self-checking bench for alu_ctrl_md against a behavioural model.
module tb_alu_ctrl_md;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  result;
  logic          zero, busy, stall, md_done;
  logic [W-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  alu_ctrl_md #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op),
    .funct(funct), .a(a), .b(b), .shamt(shamt), .alu_ctrl(alu_ctrl),
    .result(result), .zero(zero), .busy(busy), .stall(stall),
    .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'h2;
    if (op == 2'b01) return 4'h6;
    if (op == 2'b11) return 4'h1;
    case (f)
      6'h20, 6'h21: return 4'h2;
      6'h22, 6'h23: return 4'h6;
      6'h24: return 4'h0;
      6'h25: return 4'h1;
      6'h26: return 4'h3;
      6'h27: return 4'h4;
      6'h2a: return 4'h7;
      6'h2b: return 4'hb;
      6'h00: return 4'h8;
      6'h02: return 4'h9;
      6'h03: return 4'ha;
      6'h10: return 4'hc;
      6'h12: return 4'hd;
      6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: return 4'he;
      default: return 4'h2;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    case (c)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return x + y;
      4'h3: return x ^ y;
      4'h4: return ~(x | y);
      4'h6: return x - y;
      4'h7: return (sx < sy) ? 32'd1 : 32'd0;
      4'hb: return (x < y) ? 32'd1 : 32'd0;
      4'h8: return y << sh;
      4'h9: return y >> sh;
      4'ha: return 32'(sy >>> sh);
      4'hc: return m_hi;
      4'hd: return m_lo;
      default: return 32'h0;
    endcase
  endfunction

  // {hi, lo} an MD op leaves behind
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (f)
      6'h18: return 64'(sx * sy);
      6'h19: return ux * uy;
      6'h1a: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
    valid_in = v; alu_op = op; funct = f; a = x; b = y; shamt = sh;
  endtask

  // compare combinational outputs for the currently driven instruction
  task automatic check_comb(input string tag, input logic busy_e);
    logic [3:0]  c;
    logic        st;
    logic [31:0] r;
    c  = ref_ctrl(alu_op, funct);
    st = valid_in & busy_e & (c == 4'hc || c == 4'hd || c == 4'he);
    r  = st ? 32'h0 : ref_res(c, a, b, shamt);
    check({tag, "_ctrl"},   64'(alu_ctrl), 64'(c));
    check({tag, "_stall"},  64'(stall),    64'(st));
    check({tag, "_result"}, 64'(result),   64'(r));
    check({tag, "_zero"},   64'(zero),     64'(r == 32'h0));
  endtask

  task automatic rand_plain(output logic [1:0] op, output logic [5:0] f);
    logic [5:0] tab [14];
    logic [3:0] c;
    tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h3f};
    op = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) f = 6'($urandom);
    else f = tab[$urandom_range(0, 13)];
    c = ref_ctrl(2'b10, f);
    if (c == 4'hc || c == 4'hd || c == 4'he) f = 6'h3f;
  endtask

  function automatic logic [5:0] rand_hilo();
    logic [5:0] tab [8];
    tab = '{6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
    return tab[$urandom_range(0, 7)];
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // one idle-time instruction; mthi/mtlo update the model after the edge
  task automatic alu_step(input string tag, input logic v, input logic [1:0] op,
                          input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] sh);
    drive(v, op, f, x, y, sh);
    @(negedge clk);
    check_comb(tag, 1'b0);
    @(posedge clk); #1;
    if (v && op == 2'b10 && f == 6'h11) m_hi = x;
    if (v && op == 2'b10 && f == 6'h13) m_lo = x;
  endtask

  // issue an MD op from idle and follow it cycle by cycle to completion
  task automatic md_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    logic [1:0]  op;
    logic [5:0]  ff;
    logic        v;
    exp = ref_md(f, x, y);
    drive(1'b1, 2'b10, f, x, y, 5'd0);
    @(negedge clk);
    check("md_pre_busy", 64'(busy), 64'd0);
    check_comb("md_issue", 1'b0);
    @(posedge clk); #1;
    for (int j = 0; j <= W + 2; j++) begin
      v = 1'($urandom);
      if (j == W + 2) begin
        v = 1'b1; op = 2'b10; ff = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
      end else if (j <= W && $urandom_range(0, 1) == 0) begin
        op = 2'b10; ff = rand_hilo();
      end else begin
        rand_plain(op, ff);
      end
      drive(v, op, ff, rand_word(), rand_word(), 5'($urandom));
      @(negedge clk);
      check("md_busy", 64'(busy), 64'(j <= W));
      check("md_done", 64'(md_done), 64'(j == W + 1));
      check_comb("md_run", j <= W);
      if (j == W + 1) begin
        m_hi = exp[63:32];
        m_lo = exp[31:0];
      end
      if (j == W + 2) begin
        check("md_hi", 64'(hi), 64'(m_hi));
        check("md_lo", 64'(lo), 64'(m_lo));
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    int seen;
    logic [1:0] op;
    logic [5:0] f;
    logic v;
    m_hi = 32'h0; m_lo = 32'h0;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(md_done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    alu_step("slt",  1'b1, 2'b10, 6'h2a, 32'hFFFF_FFFF, 32'h1, 5'd0);
    alu_step("sltu", 1'b1, 2'b10, 6'h2b, 32'hFFFF_FFFF, 32'h1, 5'd0);
    alu_step("sra",  1'b1, 2'b10, 6'h03, 32'h0, 32'h8000_0000, 5'd4);
    alu_step("dflt", 1'b1, 2'b10, 6'h3f, 32'h5, 32'h7, 5'd0);
    alu_step("addw", 1'b1, 2'b00, 6'h0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    alu_step("mthi", 1'b1, 2'b10, 6'h11, 32'h1234_5678, 32'h0, 5'd0);
    alu_step("mtlo", 1'b1, 2'b10, 6'h13, 32'h9ABC_DEF0, 32'h0, 5'd0);
    alu_step("mfhi", 1'b1, 2'b10, 6'h10, 32'h0, 32'h0, 5'd0);
    alu_step("mflo", 1'b1, 2'b10, 6'h12, 32'h0, 32'h0, 5'd0);

    for (int i = 0; i < 150; i++) begin
      v = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        op = 2'b10; f = rand_hilo();
        if (f[5:2] == 4'b0110) v = 1'b0;
      end else begin
        rand_plain(op, f);
      end
      alu_step("rnd", v, op, f, rand_word(), rand_word(), 5'($urandom));
    end

    md_op(6'h18, 32'hFFFF_FFFD, 32'h7);
    md_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_op(6'h1a, 32'h7, 32'hFFFF_FFFE);
    md_op(6'h1b, 32'h5, 32'h0);
    md_op(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
    md_op(6'h1a, 32'hFFFF_FFF9, 32'h0);
    for (int i = 0; i < 10; i++)
      md_op(6'(8'h18 + 8'($urandom_range(0, 3))), rand_word(), rand_word());

    // reset in the middle of a multiply
    drive(1'b1, 2'b10, 6'h18, 32'h1234_5678, 32'h9, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_done", 64'(md_done), 64'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_done || busy) seen++;
    end
    check("mid_rst_quiet", 64'(seen), 64'd0);
    @(posedge clk); #1;
    md_op(6'h18, 32'hFFFF_FFFD, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
